hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side companion to operand forwarding. Tracks in-flight long-latency register writes (loads, mul/div)
//  in a per-register pending table and stalls the ID stage while an operand or destination is still in flight.
//  Sits beside the ID stage. Is set at issue and cleared by the matching writeback.
//  Carries a saturating stall-cycle counter and a sticky protocol-error flag.
// PARAMETERS
//  RADDR_WIDTH  5   register address width; table has 2**RADDR_WIDTH entries
//  CNT_WIDTH    32  stall-cycle counter width
// PORTS
//  clk               in   1            clock, all state updates on rising edge
//  rst               in   1            synchronous reset, active-high
//  id_valid_i        in   1            valid instruction in ID
//  flush_i           in   1            ID instruction squashed this cycle
//  reg1_raddr_i      in   RADDR_WIDTH  source 1 address
//  reg1_re_i         in   1            source 1 read enable
//  reg2_raddr_i      in   RADDR_WIDTH  source 2 address
//  reg2_re_i         in   1            source 2 read enable
//  id_reg_waddr_i    in   RADDR_WIDTH  ID destination address
//  id_reg_we_i       in   1            ID destination write enable
//  id_long_i         in   1            ID instruction is long-latency
//  wb_long_valid_i   in   1            long-latency result written back this cycle
//  wb_reg_waddr_i    in   RADDR_WIDTH  writeback destination address
//  stall_o           out  1            hold PC/IF/ID, insert bubble into EXE
//  stall_raw_o       out  1            stall cause: operand pending
//  stall_waw_o       out  1            stall cause: destination pending
//  busy_o            out  1            any entry pending
//  pending_o         out  2**RADDR_WIDTH pending table (debug)
//  stall_cnt_o       out  CNT_WIDTH    stall cycles since reset, saturating
//  err_o             out  1            sticky: writeback to non-pending register
// BEHAVIOUR
//  Reset (rst=1 at clk edge): pending=0, stall_cnt_o=0, err_o=0. Outputs derived from them are therefore 0.
//  Effective pending: eff[r] = pending[r] & ~(wb_long_valid_i & wb_reg_waddr_i==r).
//  The same-cycle writeback is visible to ID, because the regfile is write-first.
//  pending[0] and eff[0] are always 0. Address 0 never sets a bit, never stalls, and never flags err.
//  act = id_valid_i & ~flush_i.
//  stall_raw_o = act & ((reg1_re_i & eff[reg1_raddr_i]) | (reg2_re_i & eff[reg2_raddr_i])).
//  stall_waw_o = act & id_reg_we_i & eff[id_reg_waddr_i]. This applies to short and long ops alike, which keeps writebacks in order.
//  stall_o = stall_raw_o | stall_waw_o. All three are combinational (0-cycle latency) and may both be 1.
//  Issue: act & ~stall_o & id_reg_we_i & id_long_i & id_reg_waddr_i!=0 -> pending[id_reg_waddr_i] <= 1 next edge.
//  Clear: wb_long_valid_i & wb_reg_waddr_i!=0 -> pending[wb_reg_waddr_i] <= 0 next edge.
//  Same register set and cleared in one cycle: set wins (a new producer issued after the old one retired).
//  Short-op writebacks never touch the table.
//  err_o: wb_long_valid_i with wb_reg_waddr_i!=0 and pending[wb_reg_waddr_i]==0 -> err_o <= 1. It stays 1 until rst.
//  stall_cnt_o: +1 on every edge with stall_o=1, and holds at all-ones.
//  busy_o = |pending (registered table, not eff).
//  flush_i squashes only the ID instruction: no set and no stall. In-flight entries still await writeback.
//  Reset mid-operation: the table is cleared outright. Any writeback arriving after reset sets err_o.
// TESTING
//  T1 Load-use: issue long x5; next cycle ID reads x5 via reg1.
//     -> stall_o=stall_raw_o=1 until the wb_long_valid_i x5 cycle; stall_o=0 in that cycle; pending[5]=0 after.
//  T2 x0: long issue to x0, then ID reads x0. -> pending_o=0, stall_o=0.
//     wb_long_valid_i to x0 -> err_o stays 0.
//  T3 WAW: x7 pending; ID short op writes x7. -> stall_waw_o=1, stall_raw_o=0, until x7 writeback.
//  T4 Set/clear collide: x9 pending; writeback x9 and long issue x9 in the same cycle.
//     -> stall_o=0; pending[9]=1 after the edge.
//  T5 Flush: x3 pending; ID reads x3 with flush_i=1. -> stall_o=0, no set.
//     x3 writeback later clears pending[3]; err_o=0.
//  T6 Counter/error: CNT_WIDTH=4, stall held for 20 cycles -> stall_cnt_o=15.
//     Stray writeback to x12 -> err_o=1 and held; rst -> all zero.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register pending table for long-latency writes; stalls ID on RAW/WAW.
// Also keeps a saturating stall counter and a sticky writeback-error flag.
module hazard_scoreboard #(
  parameter int RADDR_WIDTH = 5,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic                      flush_i,
  input  logic [RADDR_WIDTH-1:0]    reg1_raddr_i,
  input  logic                      reg1_re_i,
  input  logic [RADDR_WIDTH-1:0]    reg2_raddr_i,
  input  logic                      reg2_re_i,
  input  logic [RADDR_WIDTH-1:0]    id_reg_waddr_i,
  input  logic                      id_reg_we_i,
  input  logic                      id_long_i,
  input  logic                      wb_long_valid_i,
  input  logic [RADDR_WIDTH-1:0]    wb_reg_waddr_i,
  output logic                      stall_o,
  output logic                      stall_raw_o,
  output logic                      stall_waw_o,
  output logic                      busy_o,
  output logic [2**RADDR_WIDTH-1:0] pending_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic                      err_o
);

  localparam int NREG = 2**RADDR_WIDTH;
  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [NREG-1:0]      r_pending;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;

  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_eff;
  logic            w_act;
  logic            w_raw;
  logic            w_waw;
  logic            w_stall;
  logic            w_issue;
  logic            w_wb_nz;
  logic            w_stray;

  assign w_act   = id_valid_i & ~flush_i;
  assign w_wb_nz = wb_long_valid_i & (wb_reg_waddr_i != '0);
  assign w_clr   = w_wb_nz ? (ONE << wb_reg_waddr_i) : '0;
  // Write-first regfile: a same-cycle writeback already resolves the hazard.
  assign w_eff   = r_pending & ~w_clr;

  assign w_raw = w_act &
                 ((reg1_re_i & w_eff[reg1_raddr_i]) |
                  (reg2_re_i & w_eff[reg2_raddr_i]));
  assign w_waw = w_act & id_reg_we_i & w_eff[id_reg_waddr_i];
  assign w_stall = w_raw | w_waw;

  assign w_issue = w_act & ~w_stall & id_reg_we_i &
                   id_long_i & (id_reg_waddr_i != '0);
  assign w_set   = w_issue ? (ONE << id_reg_waddr_i) : '0;
  assign w_stray = w_wb_nz & ~r_pending[wb_reg_waddr_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      // Set wins over clear: a fresh producer issued as the old one retired.
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~ONE;
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
      if (w_stray)
        r_err <= 1'b1;
    end
  end

  assign stall_o     = w_stall;
  assign stall_raw_o = w_raw;
  assign stall_waw_o = w_waw;
  assign busy_o      = |r_pending;
  assign pending_o   = r_pending;
  assign stall_cnt_o = r_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus reset,
// counter-saturation and error-flag sequences.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i, flush_i;
  logic [AW-1:0] reg1_raddr_i, reg2_raddr_i, id_reg_waddr_i, wb_reg_waddr_i;
  logic          reg1_re_i, reg2_re_i, id_reg_we_i, id_long_i, wb_long_valid_i;
  logic          stall_o, stall_raw_o, stall_waw_o, busy_o, err_o;
  logic [31:0]   pending_o;
  logic [CW-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .flush_i(flush_i),
    .reg1_raddr_i(reg1_raddr_i), .reg1_re_i(reg1_re_i),
    .reg2_raddr_i(reg2_raddr_i), .reg2_re_i(reg2_re_i),
    .id_reg_waddr_i(id_reg_waddr_i), .id_reg_we_i(id_reg_we_i),
    .id_long_i(id_long_i),
    .wb_long_valid_i(wb_long_valid_i), .wb_reg_waddr_i(wb_reg_waddr_i),
    .stall_o(stall_o), .stall_raw_o(stall_raw_o),
    .stall_waw_o(stall_waw_o), .busy_o(busy_o),
    .pending_o(pending_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  typedef struct {
    logic          v, fl;
    logic [AW-1:0] r1; logic re1;
    logic [AW-1:0] r2; logic re2;
    logic [AW-1:0] wa; logic we, lg;
    logic          wbv; logic [AW-1:0] wba;
    logic          st, raw, waw;
    int            creg;
    logic          pend, err, busy;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid_i = 0; flush_i = 0;
    reg1_raddr_i = 0; reg1_re_i = 0;
    reg2_raddr_i = 0; reg2_re_i = 0;
    id_reg_waddr_i = 0; id_reg_we_i = 0; id_long_i = 0;
    wb_long_valid_i = 0; wb_reg_waddr_i = 0;
  endtask

  function automatic vec_t mk(
    input logic v, fl, input int r1, input logic re1,
    input int r2, input logic re2, input int wa, input logic we, lg,
    input logic wbv, input int wba, input logic st, raw, waw,
    input int creg, input logic pend, err, busy);
    vec_t t;
    t.v = v; t.fl = fl;
    t.r1 = AW'(r1); t.re1 = re1; t.r2 = AW'(r2); t.re2 = re2;
    t.wa = AW'(wa); t.we = we; t.lg = lg;
    t.wbv = wbv; t.wba = AW'(wba);
    t.st = st; t.raw = raw; t.waw = waw;
    t.creg = creg; t.pend = pend; t.err = err; t.busy = busy;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  int exp_cnt;

  initial begin
    rst = 1;
    idle();
    //            v fl r1 e1 r2 e2 wa we lg wbv wba st rw ww reg pd er by
    tbl[0]  = mk(1,0, 0,0, 0,0, 5,1,1, 0, 0, 0,0,0, 5, 1,0,1);
    tbl[1]  = mk(1,0, 5,1, 0,0, 0,0,0, 0, 0, 1,1,0, 5, 1,0,1);
    tbl[2]  = mk(1,0, 5,1, 0,0, 0,0,0, 0, 0, 1,1,0, 5, 1,0,1);
    tbl[3]  = mk(1,0, 5,1, 0,0, 0,0,0, 1, 5, 0,0,0, 5, 0,0,0);
    tbl[4]  = mk(1,0, 0,0, 0,0, 0,1,1, 0, 0, 0,0,0, 0, 0,0,0);
    tbl[5]  = mk(1,0, 0,1, 0,1, 0,0,0, 1, 0, 0,0,0, 0, 0,0,0);
    tbl[6]  = mk(1,0, 0,0, 0,0, 7,1,1, 0, 0, 0,0,0, 7, 1,0,1);
    tbl[7]  = mk(1,0, 1,1, 0,0, 7,1,0, 0, 0, 1,0,1, 7, 1,0,1);
    tbl[8]  = mk(1,0, 1,1, 0,0, 7,1,0, 1, 7, 0,0,0, 7, 0,0,0);
    tbl[9]  = mk(1,0, 0,0, 0,0, 9,1,1, 0, 0, 0,0,0, 9, 1,0,1);
    tbl[10] = mk(1,0, 0,0, 0,0, 9,1,1, 1, 9, 0,0,0, 9, 1,0,1);
    tbl[11] = mk(0,0, 0,0, 0,0, 0,0,0, 1, 9, 0,0,0, 9, 0,0,0);
    tbl[12] = mk(1,0, 0,0, 0,0, 3,1,1, 0, 0, 0,0,0, 3, 1,0,1);
    tbl[13] = mk(1,1, 3,1, 3,1, 4,1,1, 0, 0, 0,0,0, 4, 0,0,1);
    tbl[14] = mk(0,0, 0,0, 0,0, 0,0,0, 1, 3, 0,0,0, 3, 0,0,0);
    tbl[15] = mk(1,0, 0,0, 0,0,10,1,1, 0, 0, 0,0,0,10, 1,0,1);
    tbl[16] = mk(1,0, 0,0,10,1,10,1,0, 0, 0, 1,1,1,10, 1,0,1);
    tbl[17] = mk(0,0, 0,0, 0,0, 0,0,0, 1,10, 0,0,0,10, 0,0,0);

    do_reset();
    chk("rst_pending", pending_o, 0);
    chk("rst_cnt", 32'(stall_cnt_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_stall", 32'(stall_o), 0);

    exp_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      id_valid_i = tbl[i].v; flush_i = tbl[i].fl;
      reg1_raddr_i = tbl[i].r1; reg1_re_i = tbl[i].re1;
      reg2_raddr_i = tbl[i].r2; reg2_re_i = tbl[i].re2;
      id_reg_waddr_i = tbl[i].wa; id_reg_we_i = tbl[i].we;
      id_long_i = tbl[i].lg;
      wb_long_valid_i = tbl[i].wbv; wb_reg_waddr_i = tbl[i].wba;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(tbl[i].st));
      chk($sformatf("v%0d_raw", i), 32'(stall_raw_o), 32'(tbl[i].raw));
      chk($sformatf("v%0d_waw", i), 32'(stall_waw_o), 32'(tbl[i].waw));
      if (tbl[i].st && exp_cnt < 15) exp_cnt++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pend", i), 32'(pending_o[tbl[i].creg]),
          32'(tbl[i].pend));
      chk($sformatf("v%0d_p0", i), 32'(pending_o[0]), 0);
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].err));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
    end
    chk("tbl_cnt", 32'(stall_cnt_o), 32'(exp_cnt));

    // Counter saturation: hold a RAW stall on x6 for 20 cycles.
    do_reset();
    @(negedge clk);
    idle();
    id_valid_i = 1; id_reg_we_i = 1; id_long_i = 1; id_reg_waddr_i = 6;
    @(negedge clk);
    idle();
    id_valid_i = 1; reg1_re_i = 1; reg1_raddr_i = 6;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 9) chk("cnt_mid", 32'(stall_cnt_o), 10);
    end
    chk("cnt_sat", 32'(stall_cnt_o), 15);
    chk("sat_stall", 32'(stall_o), 1);
    @(negedge clk);
    wb_long_valid_i = 1; wb_reg_waddr_i = 6;
    #1 chk("wb6_nostall", 32'(stall_o), 0);
    @(posedge clk); #1;
    chk("wb6_clear", 32'(pending_o[6]), 0);
    chk("wb6_err", 32'(err_o), 0);
    chk("cnt_hold", 32'(stall_cnt_o), 15);

    // Stray writeback raises the sticky error.
    @(negedge clk);
    idle();
    wb_long_valid_i = 1; wb_reg_waddr_i = 12;
    @(posedge clk); #1;
    chk("stray_err", 32'(err_o), 1);
    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", 32'(err_o), 1);

    // Reset mid-operation: x8 pending then cleared by reset.
    @(negedge clk);
    id_valid_i = 1; id_reg_we_i = 1; id_long_i = 1; id_reg_waddr_i = 8;
    @(posedge clk); #1;
    chk("x8_set", 32'(pending_o[8]), 1);
    do_reset();
    chk("rst2_pending", pending_o, 0);
    chk("rst2_cnt", 32'(stall_cnt_o), 0);
    chk("rst2_err", 32'(err_o), 0);
    chk("rst2_busy", 32'(busy_o), 0);
    @(negedge clk);
    idle();
    wb_long_valid_i = 1; wb_reg_waddr_i = 8;
    @(posedge clk); #1;
    chk("late_wb_err", 32'(err_o), 1);
    @(negedge clk);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
